// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered 4-to-2 encoder.
package enc_pkg;
    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    localparam logic IDLE = 1'b0;
    localparam logic HOLD = 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/prio_enc4.sv
// Combinational priority picker: first set bit of pend searching ptr, ptr-1, ptr-2, ptr-3 (mod 4).
module prio_enc4
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0]  pend,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] sel_code,
    output logic              hit
);
    logic [CODE_W-1:0] cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = ptr - CODE_W'(gi);
        end
    endgenerate

    // Walk from lowest to highest priority so the highest-priority hit overwrites.
    always_comb begin
        sel_code = '0;
        hit      = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pend[cand[k]]) begin
                sel_code = cand[k];
                hit      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seq_4to2_encoder.sv
// Registered 4-to-2 encoder with sticky pending bits and valid/ready output.
// Define RR_PRIORITY_EN for rotating priority; otherwise fixed order 3,2,1,0.
module seq_4to2_encoder
    import enc_pkg::*;
#(
    parameter int DROP_STICKY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic [N_REQ-1:0]  pend,
    output logic              drop
);
    logic              state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic              drop_q, drop_d;
    logic [CODE_W-1:0] ptr_w;
    logic [CODE_W-1:0] sel_code;
    logic              hit;
    logic              load;
    logic [N_REQ-1:0]  clr;
    logic              drop_hit;

`ifdef RR_PRIORITY_EN
    logic [CODE_W-1:0] ptr_q;
    assign ptr_w = ptr_q;
`else
    assign ptr_w = CODE_W'(N_REQ - 1);
`endif

    prio_enc4 u_prio (
        .pend     (pend_q),
        .ptr      (ptr_w),
        .sel_code (sel_code),
        .hit      (hit)
    );

    always_comb begin
        load     = hit && ((state_q == IDLE) || ready);
        clr      = load ? onehot(sel_code) : '0;
        // A same-cycle request re-sets a bit that is being cleared.
        pend_d   = (pend_q & ~clr) | req;
        drop_hit = |(req & pend_q & ~clr);
        drop_d   = (DROP_STICKY != 0) ? (drop_q | drop_hit) : drop_hit;

        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        if (load) begin
            state_d = HOLD;
            code_d  = sel_code;
            valid_d = 1'b1;
        end else if ((state_q == HOLD) && ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
`ifdef RR_PRIORITY_EN
            ptr_q   <= CODE_W'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
`ifdef RR_PRIORITY_EN
            if (load) begin
                ptr_q <= sel_code - CODE_W'(1);
            end
`endif
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign pend  = pend_q;
    assign drop  = drop_q;
endmodule

// File: tb/tb_seq_4to2_encoder.sv
// Directed self-checking bench for seq_4to2_encoder; honours RR_PRIORITY_EN when defined.
module tb_seq_4to2_encoder;
    localparam int TB_STICKY = 0;
`ifdef RR_PRIORITY_EN
    localparam bit TB_RR = 1'b1;
`else
    localparam bit TB_RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] code;
    logic       valid;
    logic       ready;
    logic [3:0] pend;
    logic       drop;

    int total = 0;
    int bad   = 0;

    seq_4to2_encoder #(.DROP_STICKY(TB_STICKY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .code  (code),
        .valid (valid),
        .ready (ready),
        .pend  (pend),
        .drop  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_valid, input logic [1:0] exp_code,
                           input logic [3:0] exp_pend);
        chk({tag, "_valid"}, {3'b0, valid}, {3'b0, exp_valid});
        chk({tag, "_code"},  {2'b0, code},  {2'b0, exp_code});
        chk({tag, "_pend"},  pend,          exp_pend);
        $display("step %s: valid=%b code=%b pend=%b drop=%b", tag, valid, code, pend, drop);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        ready = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 2'b00, 4'b0000);
        chk("reset_drop", {3'b0, drop}, 4'b0000);

        // Release with req still 1111: pend at first edge, valid at second.
        rst_n = 1'b1;
        step();
        chk_out("rel_e1", 1'b0, 2'b00, 4'b1111);
        req   = 4'b0000;
        ready = 1'b1;
        step();
        chk_out("rel_e2", 1'b1, 2'b11, 4'b0111);
        step();
        chk_out("drain_10", 1'b1, 2'b10, 4'b0011);
        step();
        chk_out("drain_01", 1'b1, 2'b01, 4'b0001);
        step();
        chk_out("drain_00", 1'b1, 2'b00, 4'b0000);
        step();
        chk_out("drain_end", 1'b0, 2'b00, 4'b0000);

        // Single request
        req = 4'b0100;
        step();
        req = 4'b0000;
        chk_out("single_pend", 1'b0, 2'b00, 4'b0100);
        step();
        chk_out("single_emit", 1'b1, 2'b10, 4'b0000);
        step();
        chk_out("single_end", 1'b0, 2'b10, 4'b0000);

        // Multi-hot 1011 -> 11, 01, 00
        do_reset();
        ready = 1'b1;
        req   = 4'b1011;
        step();
        req = 4'b0000;
        step();
        chk_out("multi_11", 1'b1, 2'b11, 4'b0011);
        step();
        chk_out("multi_01", 1'b1, 2'b01, 4'b0001);
        step();
        chk_out("multi_00", 1'b1, 2'b00, 4'b0000);
        step();
        chk_out("multi_end", 1'b0, 2'b00, 4'b0000);
        step();
        step();
        chk_out("idle_hold", 1'b0, 2'b00, 4'b0000);

        // Backpressure and re-request of the held code
        do_reset();
        ready = 1'b0;
        req   = 4'b1000;
        step();
        req = 4'b0000;
        step();
        chk_out("bp_load", 1'b1, 2'b11, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("bp_hold", 1'b1, 2'b11, 4'b0000);
        end
        req = 4'b1000;
        step();
        chk_out("bp_rereq", 1'b1, 2'b11, 4'b1000);
        req = 4'b0000;
        step();
        chk("bp_rereq_drop", {3'b0, drop}, 4'b0000);
        ready = 1'b1;
        step();
        chk_out("bp_second", 1'b1, 2'b11, 4'b0000);
        step();
        chk_out("bp_end", 1'b0, 2'b11, 4'b0000);

        // Drop on an already-pending bit while stalled
        do_reset();
        ready = 1'b0;
        req   = 4'b1010;
        step();
        req = 4'b0000;
        step();
        chk_out("drop_stall", 1'b1, 2'b11, 4'b0010);
        req = 4'b0010;
        step();
        chk("drop_set", {3'b0, drop}, 4'b0001);
        chk("drop_pend", pend, 4'b0010);
        req = 4'b0000;
        step();
        chk("drop_after", {3'b0, drop}, (TB_STICKY != 0) ? 4'b0001 : 4'b0000);
        ready = 1'b1;
        step();
        chk_out("drop_drain", 1'b1, 2'b01, 4'b0000);
        step();
        chk_out("drop_end", 1'b0, 2'b01, 4'b0000);

        // Collision: request on the bit being loaded keeps it pending, no drop
        do_reset();
        ready = 1'b1;
        req   = 4'b0100;
        step();
        chk("coll_pend", pend, 4'b0100);
        step();
        chk_out("coll_load", 1'b1, 2'b10, 4'b0100);
        chk("coll_drop", {3'b0, drop}, 4'b0000);
        req = 4'b0000;
        step();
        chk_out("coll_again", 1'b1, 2'b10, 4'b0000);
        step();
        chk_out("coll_end", 1'b0, 2'b10, 4'b0000);
        chk("coll_drop_end", {3'b0, drop}, 4'b0000);

        // After emitting 11, request 1001: rotating priority favours 00
        do_reset();
        ready = 1'b1;
        req   = 4'b1000;
        step();
        req   = 4'b0000;
        ready = 1'b0;
        step();
        chk_out("rr_first", 1'b1, 2'b11, 4'b0000);
        req = 4'b1001;
        step();
        chk_out("rr_pend", 1'b1, 2'b11, 4'b1001);
        chk("rr_drop", {3'b0, drop}, 4'b0000);
        req   = 4'b0000;
        ready = 1'b1;
        step();
        chk_out("rr_next", 1'b1, TB_RR ? 2'b00 : 2'b11, TB_RR ? 4'b1000 : 4'b0001);
        step();
        chk_out("rr_last", 1'b1, TB_RR ? 2'b11 : 2'b00, 4'b0000);
        step();
        chk_out("rr_end", 1'b0, TB_RR ? 2'b11 : 2'b00, 4'b0000);

        // Reset mid-handshake discards held code and pending bits
        ready = 1'b0;
        req   = 4'b0110;
        step();
        req = 4'b0000;
        step();
        chk_out("mid_hold", 1'b1, 2'b10, 4'b0010);
        rst_n = 1'b0;
        step();
        chk_out("mid_reset", 1'b0, 2'b00, 4'b0000);
        rst_n = 1'b1;
        step();
        chk_out("mid_after", 1'b0, 2'b00, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_4to2_encoder.md
Name: seq_4to2_encoder

Overview:
- Registered 4-to-2 encoder, the reverse of the team's 2-to-4 decoder: one-hot/multi-hot request lines in, 2-bit binary code out.
- Requests are captured into a sticky pending register and emitted one code at a time over a valid/ready handshake. Each granted bit is cleared.
- Fixed priority: bit 3 highest, so code 2'b11 corresponds to decoder output Y3.
- Sits upstream of the decoder so the encode/decode pair can be checked round-trip.

Parameters:
- DROP_STICKY, 0: 0 = drop is a 1-cycle pulse; 1 = drop holds until reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  4  request lines, sampled every cycle, multi-hot allowed
- code  output  2  binary index of the emitted request
- valid  output  1  code is valid
- ready  input  1  consumer accepts code when valid && ready
- pend  output  4  current pending register (status)
- drop  output  1  a request hit a bit that was already pending

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (clk, rst_n).
  - At a clk edge with rst_n=0: pend=0, code=2'b00, valid=0, drop=0, state=IDLE, RR pointer=3.
  - Reset mid-handshake discards the held code and all pending bits.
- Pending update, every edge:
  - pend_next = (pend & ~clr) | req.
  - clr is the one-hot of the code loaded this cycle (see states). It is 0 if nothing is loaded.
  - If req and clr hit the same bit in the same cycle, req wins and the bit stays set.
- drop:
  - Registered next value = |(req & pend & ~clr).
  - DROP_STICKY=0: pulse of exactly 1 cycle. DROP_STICKY=1: OR-accumulate until reset.
- Priority select:
  - Combinational over the registered pend, never over same-cycle req.
  - Fixed search order 3,2,1,0. The first set bit gives sel_code and hit=1.
- FSM, two states:
  - IDLE (valid=0): if hit, then code<=sel_code, clr=onehot(sel_code), valid<=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD (valid=1): code is held stable while ready=0.
  - HOLD with ready=1 and hit: load the next sel_code and clear it. valid stays 1 (back-to-back, 1 code/cycle).
  - HOLD with ready=1 and !hit: valid<=0, go to IDLE.
- Latency:
  - req high in cycle t: pend bit set at edge t+1, valid high from edge t+2.
  - Throughput is 1 code/cycle when ready is held high.
- Re-request of the bit currently held in code (already cleared from pend) sets pend again and produces a second emission later. This does not count as a drop.
- req=0000 forever: valid stays 0, code holds its last value.

Optional Feature:
- Macro RR_PRIORITY_EN.
- Defined: rotating priority with a 2-bit pointer ptr (reset 3).
  - Search order is ptr, ptr-1, ptr-2, ptr-3, all mod 4.
  - After a code k is loaded, ptr <= k-1 mod 4.
- Undefined: fixed order 3,2,1,0. No pointer register exists.

Decomposition:
- Package enc_pkg:
  - N_REQ=4, CODE_W=2.
  - State localparams IDLE=1'b0, HOLD=1'b1.
  - onehot function mapping a 2-bit code to 4 bits.
- Sub-module prio_enc4: combinational.
  - Inputs: pend[3:0], ptr[1:0].
  - Outputs: sel_code[1:0], hit.
  - ptr is tied to 3 when RR_PRIORITY_EN is undefined.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=1111 -> pend=0000, valid=0, code=00, drop=0. Release -> valid=1 at the second edge after release.
- Single request: req=0100 for 1 cycle, ready=1 -> valid=1, code=10 for exactly 1 cycle, 2 edges after the req cycle. Then pend=0000 and valid=0.
- Multi-hot, fixed priority: req=1011 for 1 cycle, ready=1 -> codes 11,01,00 on consecutive cycles, then valid=0.
- Backpressure plus re-request: req=1000 once, ready=0 for 5 cycles -> code=11 held stable. Pulse req=1000 again during the hold -> pend=1000, drop=0. Then ready=1 -> code 11 is emitted twice.
- Drop and collision: pend=0010 (stalled), req=0010 -> drop pulses 1 cycle (DROP_STICKY=0) or stays high (DROP_STICKY=1). A req on the bit cleared by the same-cycle load -> bit stays set, drop=0.
- RR_PRIORITY_EN defined, req=1111 once, ready=1 -> codes 11,10,01,00. Then req=1001 -> 00 is not first: order from ptr=3 gives 11, then 00.
